// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// Optional alert blinking is enabled with SEG_ARB_BLINK_EN.
package seg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      HOLD_SONG  = 2'd1,
      HOLD_ALERT = 2'd2
   } state_e;

   localparam logic [1:0] SRC_BG    = 2'd0;
   localparam logic [1:0] SRC_SONG  = 2'd1;
   localparam logic [1:0] SRC_ALERT = 2'd2;

   localparam logic [3:0] DIG_0 = 4'b1000;
   localparam logic [3:0] DIG_1 = 4'b0100;
   localparam logic [3:0] DIG_2 = 4'b0010;
   localparam logic [3:0] DIG_3 = 4'b0001;

   function automatic logic [3:0] dig_onehot(
      input logic [1:0] idx
   );
      logic [3:0] r;
      case (idx)
         2'd0:    r = DIG_0;
         2'd1:    r = DIG_1;
         2'd2:    r = DIG_2;
         default: r = DIG_3;
      endcase
      return r;
   endfunction

   // Digit 0 is the leftmost one and owns the top byte.
   function automatic logic [7:0] frame_byte(
      input logic [31:0] f,
      input logic [1:0]  idx
   );
      logic [7:0] r;
      case (idx)
         2'd0:    r = f[31:24];
         2'd1:    r = f[23:16];
         2'd2:    r = f[15:8];
         default: r = f[7:0];
      endcase
      return r;
   endfunction

   function automatic logic [1:0] src_of(
      input state_e s
   );
      logic [1:0] r;
      case (s)
         HOLD_SONG:  r = SRC_SONG;
         HOLD_ALERT: r = SRC_ALERT;
         default:    r = SRC_BG;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Free-running prescaler: one-cycle tick every SCAN_DIV clocks.
// Shared by the display blocks that need a digit-scan cadence.
module seg_scan_tick #(
   parameter int SCAN_DIV = 250000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick  = (cnt_q == LAST);
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// Arbitrates background/song/alert frames onto a scanned 4-digit display.
// Define SEG_ARB_BLINK_EN to blink the alert frame.
module seg_display_arbiter
   import seg_arb_pkg::*;
#(
   parameter int         SCAN_DIV   = 250000,
   parameter int         HOLD_TICKS = 800,
   parameter int         BLINK_HALF = 100,
   parameter logic [7:0] BLANK_CODE = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] bg_frame,
   input  logic        song_valid,
   input  logic [31:0] song_frame,
   output logic        song_ready,
   input  logic        alert_valid,
   input  logic [31:0] alert_frame,
   output logic        alert_ready,
   output logic [3:0]  sel,
   output logic [7:0]  seg,
   output logic [1:0]  active_src
);

   localparam logic [15:0] HOLD_LD = 16'(HOLD_TICKS);

   state_e      state_q, state_d;
   logic [31:0] frame_q, frame_d;
   logic [15:0] hold_q, hold_d;
   logic [1:0]  dig_q, dig_d;
   logic [3:0]  sel_q;
   logic [7:0]  seg_q;
   logic [1:0]  src_q;
   logic        tick;
   logic        alert_xfer;
   logic        song_xfer;
   logic        hold_step;
   logic        blank_w;
   logic [31:0] show_w;
   logic [7:0]  byte_w;

   seg_scan_tick #(
      .SCAN_DIV(SCAN_DIV)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   assign song_ready  = (state_q != HOLD_ALERT) && !alert_valid;
   assign alert_ready = 1'b1;
   assign alert_xfer  = alert_valid;
   assign song_xfer   = song_valid && song_ready;
   assign hold_step   = tick && (state_q != IDLE)
                        && !alert_xfer && !song_xfer;

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      hold_d  = hold_q;
      unique case (1'b1)
         alert_xfer: begin
            state_d = HOLD_ALERT;
            frame_d = alert_frame;
            hold_d  = HOLD_LD;
         end
         song_xfer: begin
            state_d = HOLD_SONG;
            frame_d = song_frame;
            hold_d  = HOLD_LD;
         end
         hold_step: begin
            hold_d = hold_q - 16'd1;
            if (hold_q == 16'd1) state_d = IDLE;
         end
         default: ;
      endcase
   end

   // The scan uses the frame of the state in force at the tick edge.
   assign dig_d  = tick ? dig_q + 2'd1 : dig_q;
   assign show_w = (state_q == IDLE) ? bg_frame : frame_q;
   assign byte_w = frame_byte(show_w, dig_d);

`ifdef SEG_ARB_BLINK_EN
   localparam logic [15:0] BL_LAST = 16'(BLINK_HALF - 1);

   logic        blink_on_q;
   logic [15:0] blink_cnt_q;

   assign blank_w = (state_q == HOLD_ALERT) && !blink_on_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_on_q  <= 1'b1;
         blink_cnt_q <= '0;
      end else if (alert_xfer) begin
         blink_on_q  <= 1'b1;
         blink_cnt_q <= '0;
      end else if (tick && state_q == HOLD_ALERT) begin
         if (blink_cnt_q == BL_LAST) begin
            blink_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 16'd1;
         end
      end
   end
`else
   logic unused_blink;
   assign unused_blink = ^32'(BLINK_HALF);
   assign blank_w      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         frame_q <= '0;
         hold_q  <= '0;
         dig_q   <= 2'd3;
         sel_q   <= 4'b0000;
         seg_q   <= BLANK_CODE;
         src_q   <= SRC_BG;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         hold_q  <= hold_d;
         dig_q   <= dig_d;
         src_q   <= src_of(state_d);
         if (tick) begin
            sel_q <= dig_onehot(dig_d);
            seg_q <= blank_w ? BLANK_CODE : byte_w;
         end
      end
   end

   assign sel        = sel_q;
   assign seg        = seg_q;
   assign active_src = src_q;

endmodule
